// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory bus between fetch (I) and data (D) ports
// D has fixed priority; fetch wins after STARVE_LIMIT contested D-grants; flushed fetch responses are dropped.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ready,
  input  logic        i_flush,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_be,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        bus_req_valid,
  output logic [31:0] bus_req_addr,
  output logic        bus_req_we,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_be,
  input  logic        bus_req_ready,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_data,
  output logic        busy,
  output logic        err_spurious
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state_q, state_d;
  logic               owner_i_q, owner_i_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               err_q, err_d;
  logic               bus_valid_q, bus_valid_d;
  logic [31:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;

  logic               i_live;
  logic               grant_i;
  logic               grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_i_q    <= 1'b0;
      drop_q       <= 1'b0;
      starve_cnt_q <= '0;
      err_q        <= 1'b0;
      bus_valid_q  <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      state_q      <= state_d;
      owner_i_q    <= owner_i_d;
      drop_q       <= drop_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
      bus_valid_q  <= bus_valid_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
    end
  end

  // A flushed fetch request is not a live contender for arbitration.
  assign i_live  = i_req_valid && !i_flush;
  assign grant_i = (state_q == IDLE) && i_live &&
                   (!d_req_valid || (starve_cnt_q == CNT_W'(STARVE_LIMIT)));
  assign grant_d = (state_q == IDLE) && d_req_valid && !grant_i;

  always_comb begin
    state_d      = state_q;
    owner_i_d    = owner_i_q;
    drop_d       = drop_q;
    starve_cnt_d = starve_cnt_q;
    err_d        = err_q;
    bus_valid_d  = bus_valid_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    i_rsp_valid  = 1'b0;
    d_rsp_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus_rsp_valid) err_d = 1'b1;
        if (grant_i) begin
          state_d      = ISSUE;
          owner_i_d    = 1'b1;
          drop_d       = 1'b0;
          bus_valid_d  = 1'b1;
          addr_d       = i_req_addr;
          we_d         = 1'b0;
          wdata_d      = '0;
          be_d         = 4'hF;
          starve_cnt_d = '0;
        end else if (grant_d) begin
          state_d     = ISSUE;
          owner_i_d   = 1'b0;
          drop_d      = 1'b0;
          bus_valid_d = 1'b1;
          addr_d      = d_req_addr;
          we_d        = d_req_we;
          wdata_d     = d_req_wdata;
          be_d        = d_req_be;
          if (i_live && (starve_cnt_q != CNT_W'(STARVE_LIMIT)))
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end
      ISSUE: begin
        if (bus_rsp_valid) err_d = 1'b1;
        if (owner_i_q && i_flush) drop_d = 1'b1;
        if (bus_req_ready) begin
          bus_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (owner_i_q && i_flush) drop_d = 1'b1;
        if (bus_rsp_valid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (owner_i_q) i_rsp_valid = !drop_q && !i_flush;
          else           d_rsp_valid = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  assign i_req_ready   = grant_i;
  assign d_req_ready   = grant_d;
  assign i_rsp_data    = i_rsp_valid ? bus_rsp_data : 32'h0;
  assign d_rsp_data    = d_rsp_valid ? bus_rsp_data : 32'h0;
  assign bus_req_valid = bus_valid_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_we    = we_q;
  assign bus_req_wdata = wdata_q;
  assign bus_req_be    = be_q;
  assign busy          = (state_q != IDLE);
  assign err_spurious  = err_q;

endmodule
